// File: rtl/traffic_phase_controller.sv
// Two-street traffic phase sequencer driven by a 1 Hz tick; also produces per-street countdowns.
// Optional night flashing mode is built when TRAFFIC_NIGHT_FLASH_EN is defined.
module traffic_phase_controller #(
   parameter int GREEN_TIME   = 25,
   parameter int YELLOW_TIME  = 3,
   parameter int ALL_RED_TIME = 2,
   parameter int COUNT_WIDTH  = 6
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   tick,
   input  logic                   hold,
`ifdef TRAFFIC_NIGHT_FLASH_EN
   input  logic                   night_mode,
`endif
   output logic [2:0]             row_traffic_lights,
   output logic [2:0]             column_traffic_lights,
   output logic [COUNT_WIDTH-1:0] row_remaining,
   output logic [COUNT_WIDTH-1:0] column_remaining,
   output logic [2:0]             phase
);

   typedef enum logic [2:0] {
      ROW_GREEN  = 3'd0,
      ROW_YELLOW = 3'd1,
      ALL_RED_1  = 3'd2,
      COL_GREEN  = 3'd3,
      COL_YELLOW = 3'd4,
`ifdef TRAFFIC_NIGHT_FLASH_EN
      ALL_RED_2  = 3'd5,
      FLASH      = 3'd6
`else
      ALL_RED_2  = 3'd5
`endif
   } state_t;

   localparam logic [COUNT_WIDTH-1:0] G_W = COUNT_WIDTH'(GREEN_TIME);
   localparam logic [COUNT_WIDTH-1:0] Y_W = COUNT_WIDTH'(YELLOW_TIME);
   localparam logic [COUNT_WIDTH-1:0] R_W = COUNT_WIDTH'(ALL_RED_TIME);

   localparam logic [2:0] LIGHT_RED    = 3'b100;
   localparam logic [2:0] LIGHT_YELLOW = 3'b010;
   localparam logic [2:0] LIGHT_GREEN  = 3'b001;

   state_t                 state_reg, state_next;
   logic [COUNT_WIDTH-1:0] timer_reg, timer_next;
   logic                   advance;
   logic                   legal;
`ifdef TRAFFIC_NIGHT_FLASH_EN
   logic                   flash_reg, flash_next;
`endif

   function automatic state_t successor(input state_t s);
      case (s)
         ROW_GREEN:  return ROW_YELLOW;
         ROW_YELLOW: return ALL_RED_1;
         ALL_RED_1:  return COL_GREEN;
         COL_GREEN:  return COL_YELLOW;
         COL_YELLOW: return ALL_RED_2;
         ALL_RED_2:  return ROW_GREEN;
         default:    return ALL_RED_2;
      endcase
   endfunction

   function automatic logic [COUNT_WIDTH-1:0] duration(input state_t s);
      case (s)
         ROW_GREEN, COL_GREEN:   return G_W;
         ROW_YELLOW, COL_YELLOW: return Y_W;
         default:                return R_W;
      endcase
   endfunction

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg <= ALL_RED_2;
         timer_reg <= R_W;
`ifdef TRAFFIC_NIGHT_FLASH_EN
         flash_reg <= 1'b0;
`endif
      end else begin
         state_reg <= state_next;
         timer_reg <= timer_next;
`ifdef TRAFFIC_NIGHT_FLASH_EN
         flash_reg <= flash_next;
`endif
      end
   end

   always_comb begin
      state_next            = state_reg;
      timer_next            = timer_reg;
      row_traffic_lights    = LIGHT_RED;
      column_traffic_lights = LIGHT_RED;
      row_remaining         = '0;
      column_remaining      = '0;
      advance               = tick && !hold;
      legal                 = (state_reg <= ALL_RED_2);
`ifdef TRAFFIC_NIGHT_FLASH_EN
      flash_next            = flash_reg;
`endif

      if (advance) begin
`ifdef TRAFFIC_NIGHT_FLASH_EN
         // Night request wins over normal sequencing; flash starts on the yellow half.
         if (night_mode) begin
            state_next = FLASH;
            timer_next = '0;
            flash_next = (state_reg == FLASH) ? !flash_reg : 1'b1;
         end else if (state_reg == FLASH) begin
            state_next = ALL_RED_2;
            timer_next = R_W;
            flash_next = 1'b0;
         end else
`endif
         if (!legal || timer_reg == '0) begin
            state_next = ALL_RED_2;
            timer_next = R_W;
         end else if (timer_reg == COUNT_WIDTH'(1)) begin
            state_next = successor(state_reg);
            timer_next = duration(state_next);
         end else begin
            timer_next = timer_reg - COUNT_WIDTH'(1);
         end
      end

      // Remaining = time left in this state plus every later state before this street's colour changes.
      case (state_reg)
         ROW_GREEN: begin
            row_traffic_lights = LIGHT_GREEN;
            row_remaining      = timer_reg + Y_W;
            column_remaining   = timer_reg + Y_W + R_W;
         end
         ROW_YELLOW: begin
            row_traffic_lights = LIGHT_YELLOW;
            row_remaining      = timer_reg;
            column_remaining   = timer_reg + R_W;
         end
         ALL_RED_1: begin
            row_remaining      = timer_reg + G_W + Y_W + R_W;
            column_remaining   = timer_reg;
         end
         COL_GREEN: begin
            column_traffic_lights = LIGHT_GREEN;
            row_remaining         = timer_reg + Y_W + R_W;
            column_remaining      = timer_reg + Y_W;
         end
         COL_YELLOW: begin
            column_traffic_lights = LIGHT_YELLOW;
            row_remaining         = timer_reg + R_W;
            column_remaining      = timer_reg;
         end
         ALL_RED_2: begin
            row_remaining      = timer_reg;
            column_remaining   = timer_reg + G_W + Y_W + R_W;
         end
`ifdef TRAFFIC_NIGHT_FLASH_EN
         FLASH: begin
            row_traffic_lights    = flash_reg ? LIGHT_YELLOW : 3'b000;
            column_traffic_lights = flash_reg ? LIGHT_YELLOW : 3'b000;
         end
`endif
         default: begin
            row_traffic_lights    = LIGHT_RED;
            column_traffic_lights = LIGHT_RED;
         end
      endcase
   end

   assign phase = state_reg;

endmodule

// File: doc/traffic_phase_controller.md
Name: traffic_phase_controller

Overview:
- Sequences a two-street intersection (row street, column street) through green, yellow and all-red phases, timed by a 1 Hz tick enable.
- Drives both light triplets.
- Produces per-street binary countdown values that feed the binary-to-BCD converters and seven-segment displays in the traffic light top level.
- Replaces the free-running down counter as the single timing authority.

Parameters:
- GREEN_TIME, 25, ticks a street holds green (>=1)
- YELLOW_TIME, 3, ticks a street holds yellow (>=1)
- ALL_RED_TIME, 2, ticks both streets hold red between greens (>=1)
- COUNT_WIDTH, 6, width of timer and countdown outputs
- Legality: GREEN_TIME+YELLOW_TIME+2*ALL_RED_TIME <= min(2^COUNT_WIDTH-1, 99)

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- tick  input  1  one-cycle enable, nominally 1 Hz; each high cycle counts once
- hold  input  1  freezes the timer and state while high
- row_traffic_lights  output  3  {red,yellow,green}, one-hot
- column_traffic_lights  output  3  {red,yellow,green}, one-hot
- row_remaining  output  COUNT_WIDTH  ticks until the row light next changes colour
- column_remaining  output  COUNT_WIDTH  ticks until the column light next changes colour
- phase  output  3  current state code, for debug

Behaviour:
- State codes: ROW_GREEN=0, ROW_YELLOW=1, ALL_RED_1=2, COL_GREEN=3, COL_YELLOW=4, ALL_RED_2=5, FLASH=6 (FLASH only with the optional feature).
- Cycle order: ROW_GREEN -> ROW_YELLOW -> ALL_RED_1 -> COL_GREEN -> COL_YELLOW -> ALL_RED_2 -> ROW_GREEN.
- Reset (async): state=ALL_RED_2, timer=ALL_RED_TIME, both lights=100.
  - row_remaining=ALL_RED_TIME
  - column_remaining=ALL_RED_TIME+GREEN_TIME+YELLOW_TIME+ALL_RED_TIME
  - Reset mid-phase takes effect immediately, regardless of tick or hold.
- Timer is loaded with the full duration of the entered state.
- On each clock edge with tick=1 and hold=0:
  - if timer==1, advance to the next state and load its duration;
  - else timer decrements by 1.
- Each state therefore lasts exactly its duration in ticks. Full cycle = 2*(GREEN_TIME+YELLOW_TIME+ALL_RED_TIME) ticks.
- hold=1 overrides tick: no timer or state change. Outputs stay constant.
- Timer never reaches 0 in normal operation. If it is ever 0, the next tick forces ALL_RED_2 with timer=ALL_RED_TIME (recovery).
- Lights are a combinational decode of state, with no latency after the state edge:
  - ROW_GREEN: row 001, column 100
  - ROW_YELLOW: row 010, column 100
  - ALL_RED_1 and ALL_RED_2: both 100
  - COL_GREEN: row 100, column 001
  - COL_YELLOW: row 100, column 010
- row_remaining (G/Y/R = GREEN_TIME/YELLOW_TIME/ALL_RED_TIME):
  - ROW_GREEN: timer+Y
  - ROW_YELLOW: timer
  - ALL_RED_1: timer+G+Y+R
  - COL_GREEN: timer+Y+R
  - COL_YELLOW: timer+R
  - ALL_RED_2: timer
- column_remaining: the same table with row and column roles swapped. ALL_RED_2 gives timer+G+Y+R; ALL_RED_1 gives timer.
- Sums are computed at COUNT_WIDTH. The legality rule guarantees no overflow.
- Never both streets non-red. Any illegal state code decodes to both red and recovers to ALL_RED_2 on the next tick.

Optional Feature:
- Macro: TRAFFIC_NIGHT_FLASH_EN.
- Defined: adds input night_mode (1 bit), sampled only on tick cycles with hold=0.
  - night_mode=1 on a tick, from any state: enter FLASH. Both lights show 010 and 000 alternately, toggling every tick and starting at 010. Both remaining outputs=0. phase=6.
  - night_mode=0 on a tick while in FLASH: go to ALL_RED_2 with timer=ALL_RED_TIME. Normal cycle then resumes.
  - Reset clears the flash toggle and leaves FLASH.
- Undefined: no night_mode port, no FLASH state. phase never equals 6.

Test Plan:
- Reset check (G=4, Y=2, R=1): assert reset mid-clock -> lights immediately 100/100, phase=5, row_remaining=1, column_remaining=8.
- Normal cycle (G=4, Y=2, R=1): one tick after reset -> phase=0, row 001, column 100, row_remaining=6, column_remaining=7. Continue ticking -> phases 0,0,0,0,1,1,2,3,3,3,3,4,4,5 and repeat every 14 ticks. Row and column never green/yellow together.
- Hold priority: hold=1 with tick=1 for 5 cycles in phase=0, timer=3 -> phase, timer and outputs unchanged. Releasing hold resumes from timer=3.
- Tick gating: clock for 20 cycles with tick=0 -> no change. tick held high 3 consecutive cycles -> timer decrements by 3.
- Async reset mid-phase: reset pulse during COL_YELLOW between clock edges -> outputs return to reset values before the next clock edge.
- With TRAFFIC_NIGHT_FLASH_EN: night_mode=1 on a tick in ROW_GREEN -> phase=6, lights 010/010, then 000/000 on the next tick. night_mode=0 on a tick -> phase=5, row_remaining=1.
